// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit.
// The write-protect option is enabled by defining LSU_WPROT_EN.
package lsu_pkg;

    localparam int LSU_ADDR_W = 8;
    localparam int LSU_DATA_W = 8;
    localparam logic [7:0] LSU_WPROT_LIMIT = 8'h0F;

    localparam logic LSU_OP_LOAD  = 1'b0;
    localparam logic LSU_OP_STORE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    function automatic lsu_state_t lsu_op_state(input logic op);
        return (op == LSU_OP_STORE) ? STORE : LOAD;
    endfunction

endpackage

// File: rtl/lsu_wprot.sv
// Address-versus-limit comparator for store write protection.
// Only instantiated when LSU_WPROT_EN is defined.
module lsu_wprot #(
    parameter int                ADDR_W = 8,
    parameter logic [ADDR_W-1:0] LIMIT  = '0
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_prot
);

    assign o_prot = (i_addr <= LIMIT);

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer for the 256x8 data memory (falling-edge write,
// combinational read). Define LSU_WPROT_EN to block stores at or below WPROT_LIMIT.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int                ADDR_W      = LSU_ADDR_W,
    parameter int                DATA_W      = LSU_DATA_W,
    parameter logic [ADDR_W-1:0] WPROT_LIMIT = LSU_WPROT_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic              w_accept;
    logic              w_is_store;
    logic              w_prot;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_wr;
    logic              r_rd;

    assign w_accept   = req_valid && req_ready;
    assign w_is_store = (req_store == LSU_OP_STORE);

`ifdef LSU_WPROT_EN
    logic r_err;

    lsu_wprot #(
        .ADDR_W (ADDR_W),
        .LIMIT  (WPROT_LIMIT)
    ) u_wprot (
        .i_addr (req_addr),
        .o_prot (w_prot)
    );

    // Error is decided at accept time and held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_is_store && w_prot;
        end
    end

    assign resp_err = r_err;
`else
    logic w_unused_limit;

    assign w_prot         = 1'b0;
    assign resp_err       = 1'b0;
    assign w_unused_limit = ^WPROT_LIMIT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next = lsu_op_state(req_store);
                end
            end
            LOAD, STORE: begin
                w_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    w_next = req_valid ? lsu_op_state(req_store) : IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
            end
            RESP: begin
                req_ready  = resp_ready;
                resp_valid = 1'b1;
            end
            default: begin
                req_ready  = 1'b0;
                resp_valid = 1'b0;
            end
        endcase
    end

    // Memory strobes are registered so they are clean for the whole cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= req_addr;
                if (w_is_store) begin
                    r_wdata <= req_wdata;
                end
            end
            r_rd <= w_accept && !w_is_store;
            r_wr <= w_accept && w_is_store && !w_prot;
        end
    end

    // mem_rdata is only looked at while the read strobe is up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (r_state == LOAD) begin
            r_rdata <= mem_rdata;
        end else if (r_state == STORE) begin
            r_rdata <= '0;
        end
    end

    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_wr     = r_wr;
    assign mem_rd     = r_rd;
    assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 256x8 memory.
// Build with +define+LSU_WPROT_EN to exercise write protection.
module tb_load_store_unit;

    typedef struct {
        logic [7:0] rd;
        logic       err;
        bit         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_store = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [7:0] resp_rdata;
    logic       resp_err;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wr;
    logic       mem_rd;
    wire  [7:0] mem_rdata;

    logic [7:0] mem [256];
    exp_t       exp_q[$];
    int         acc_q[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         wr0f = 0;
    logic [7:0] prev_rdata = '0;
    logic       prev_rd = 1'b0;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    assign mem_rdata = mem_rd ? mem[mem_addr] : 8'bz;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard on each response handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdata = '0;
            prev_rd    = 1'b0;
        end else begin
            check("rd_wr_excl", int'(mem_rd && mem_wr), 0);
            if (mem_wr && mem_addr == 8'h0F) wr0f++;
            if (resp_rdata != prev_rdata && resp_rdata != 8'h00)
                check("rdata_only_from_load", int'(prev_rd), 1);
            if (req_valid && req_ready) acc_q.push_back(cyc + 1);
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    int   a;
                    e = exp_q.pop_front();
                    a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
                    check("resp_rdata", int'(resp_rdata), int'(e.rd));
                    check("resp_err", int'(resp_err), int'(e.err));
                    if (e.lat) check("resp_latency", cyc + 1 - a, 2);
                end
            end
            prev_rdata = resp_rdata;
            prev_rd    = mem_rd;
        end
    end

    task automatic issue(input bit st, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] xrd,
                         input bit xerr, input bit lat);
        int n;
        exp_t e;
        e.rd  = xrd;
        e.err = xerr;
        e.lat = lat;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_store = st;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 50);
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            void'(exp_q.pop_back());
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            acc_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h3C;
        mem[8'h11] = 8'h7E;
        mem[8'h20] = 8'h11;
        mem[8'h0F] = 8'h22;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_mem_rd", int'(mem_rd), 0);
        check("rst_mem_wr", int'(mem_wr), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // store then load same address
        issue(1'b1, 8'h40, 8'hA5, 8'h00, 1'b0, 1'b1);
        issue(1'b0, 8'h40, 8'h00, 8'hA5, 1'b0, 1'b1);
        drain();

        // back-to-back loads
        issue(1'b0, 8'h10, 8'h00, 8'h3C, 1'b0, 1'b1);
        issue(1'b0, 8'h11, 8'h00, 8'h7E, 1'b0, 1'b1);
        drain();

        // response stall
        resp_ready = 1'b0;
        issue(1'b0, 8'h11, 8'h00, 8'h7E, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_resp_valid", int'(resp_valid), 1);
            check("stall_rdata", int'(resp_rdata), 8'h7E);
            check("stall_req_ready", int'(req_ready), 0);
            check("stall_mem_rd", int'(mem_rd), 0);
            check("stall_mem_wr", int'(mem_wr), 0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        drain();

        // reset during STORE before the falling edge
        issue(1'b1, 8'h20, 8'h99, 8'h00, 1'b0, 1'b0);
        check("store_strobe_up", int'(mem_wr), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", int'(req_ready), 1);
        check("arst_resp_valid", int'(resp_valid), 0);
        check("arst_resp_rdata", int'(resp_rdata), 0);
        check("arst_resp_err", int'(resp_err), 0);
        check("arst_mem_wr", int'(mem_wr), 0);
        check("arst_mem_rd", int'(mem_rd), 0);
        check("arst_mem_addr", int'(mem_addr), 0);
        check("arst_mem_wdata", int'(mem_wdata), 0);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("arst_mem_unchanged", int'(mem[8'h20]), 8'h11);
        issue(1'b0, 8'h20, 8'h00, 8'h11, 1'b0, 1'b1);
        drain();

        // write-protect boundary
`ifdef LSU_WPROT_EN
        issue(1'b1, 8'h0F, 8'h55, 8'h00, 1'b1, 1'b1);
        issue(1'b0, 8'h0F, 8'h00, 8'h22, 1'b0, 1'b1);
`else
        issue(1'b1, 8'h0F, 8'h55, 8'h00, 1'b0, 1'b1);
        issue(1'b0, 8'h0F, 8'h00, 8'h55, 1'b0, 1'b1);
`endif
        issue(1'b1, 8'h10, 8'h66, 8'h00, 1'b0, 1'b1);
        issue(1'b0, 8'h10, 8'h00, 8'h66, 1'b0, 1'b1);
        drain();
`ifdef LSU_WPROT_EN
        check("wprot_wr_cycles", wr0f, 0);
        check("wprot_mem_0f", int'(mem[8'h0F]), 8'h22);
`else
        check("store_wr_cycles", wr0f, 1);
        check("store_mem_0f", int'(mem[8'h0F]), 8'h55);
`endif
        check("store_mem_10", int'(mem[8'h10]), 8'h66);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
